// File: rtl/sram_controller_if.sv
// MEM-stage request port and external 16-bit SRAM pins of the data-memory controller.
interface sram_controller_if #(
    parameter int SRAM_AW = 18
);
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses (low half first),
// holding each half for WAIT_CYCLES clocks and stalling the pipeline through ready.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sram_controller_if.slave  bus
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                isWrite_q, isWrite_d;
    logic [SRAM_AW-2:0]  word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  addrHold_q, addrHold_d;
    logic [15:0]         dqHold_q, dqHold_d;

    logic [31:0]         offset;
    logic                unusedBits;
    logic                request;
    logic                lastCount;
    logic                highHalf;
    logic [SRAM_AW-1:0]  curAddr;
    logic [15:0]         curDq;

    // Only the word index survives; the byte lane and bits beyond the SRAM span wrap away.
    assign offset     = bus.address - 32'(BASE_ADDR);
    assign unusedBits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign request    = bus.rd_en | bus.wr_en;
    assign lastCount  = (cnt_q == LastCount);
    assign highHalf   = (state_q == HIGH);
    assign curAddr    = {word_q, highHalf};
    assign curDq      = highHalf ? wdata_q[31:16] : wdata_q[15:0];
    assign bus.read_data = rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            isWrite_q  <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addrHold_q <= '0;
            dqHold_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            isWrite_q  <= isWrite_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addrHold_q <= addrHold_d;
            dqHold_q   <= dqHold_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        isWrite_d       = isWrite_q;
        word_d          = word_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        addrHold_d      = addrHold_q;
        dqHold_d        = dqHold_q;
        bus.ready       = 1'b0;
        bus.sram_addr   = addrHold_q;
        bus.sram_dq_out = dqHold_q;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;

        unique case (state_q)
            IDLE: begin
                bus.ready = ~request;
                if (request) begin
                    state_d   = LOW;
                    cnt_d     = '0;
                    isWrite_d = bus.wr_en;
                    word_d    = offset[SRAM_AW:2];
                    wdata_d   = bus.write_data;
                end
            end
            LOW, HIGH: begin
                bus.sram_addr = curAddr;
                addrHold_d    = curAddr;
                // The strobe rises one count early so address and data are held past it.
                if (isWrite_q) begin
                    bus.sram_dq_out = curDq;
                    dqHold_d        = curDq;
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = lastCount;
                end
                cnt_d = cnt_q + 1'b1;
                if (lastCount) begin
                    cnt_d   = '0;
                    state_d = highHalf ? DONE : HIGH;
                    if (!isWrite_q) begin
                        if (highHalf) rdata_d[31:16] = bus.sram_dq_in;
                        else          rdata_d[15:0]  = bus.sram_dq_in;
                    end
                end
            end
            DONE: begin
                bus.ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
